// File: rtl/array_alloc_pkg.sv
// Shared types and constants for the array heap allocator.
// Imported by the allocator, its arbiter and the requester interface.
package array_alloc_pkg;

    localparam int MEM_ELEM_W = 12;

    localparam logic OP_ALLOC = 1'b0;
    localparam logic OP_FREE  = 1'b1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

    typedef logic [MEM_ELEM_W-1:0] handle_t;

endpackage

// File: rtl/array_allocator_if.sv
// Requester-side bus of the array allocator: request inputs, per-requester
// ack and shared response/status outputs.
interface array_allocator_if #(
    parameter int MemoryElementWidth = 12,
    parameter int NReq               = 2
);
    logic [NReq-1:0]                    req_valid;
    logic [NReq-1:0]                    req_free;
    logic [NReq*MemoryElementWidth-1:0] req_array;
    logic [NReq-1:0]                    ack;
    logic [MemoryElementWidth-1:0]      rsp_array;
    logic                               rsp_error;
    logic                               size_clr;
    logic [MemoryElementWidth-1:0]      size_clr_idx;
    logic [MemoryElementWidth-1:0]      allocs;
    logic [MemoryElementWidth-1:0]      in_use;
    logic                               busy;

    modport master (
        output req_valid, req_free, req_array,
        input  ack, rsp_array, rsp_error, size_clr, size_clr_idx,
        input  allocs, in_use, busy
    );

    modport slave (
        input  req_valid, req_free, req_array,
        output ack, rsp_array, rsp_error, size_clr, size_clr_idx,
        output allocs, in_use, busy
    );
endinterface

// File: rtl/array_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after
// i_ptr (wrapping) wins; the pointer register lives in the parent.
module rr_arbiter #(
    parameter int NReq  = 2,
    parameter int PTR_W = 1
) (
    input  logic [NReq-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [NReq-1:0]  o_grant,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_any
);

    logic             w_found;
    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int i = 0; i < NReq; i++) begin
            w_sum = {1'b0, i_ptr} + (PTR_W+1)'(i);
            if (w_sum >= (PTR_W+1)'(NReq))
                w_sum = w_sum - (PTR_W+1)'(NReq);
            w_cand = w_sum[PTR_W-1:0];
            if (!w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/array_allocator.sv
// Array heap allocator: freed-handle LIFO, high-water counter and in-use
// bitmap, serving NReq requesters round-robin through a two-state FSM.
module array_allocator
    import array_alloc_pkg::*;
#(
    parameter int MemoryElementWidth = MEM_ELEM_W,
    parameter int NArrays            = 16,
    parameter int NReq               = 2
) (
    input  logic          clock,
    input  logic          run,
    array_allocator_if.slave bus
);

    localparam int MW    = MemoryElementWidth;
    localparam int PTR_W = (NReq > 1) ? $clog2(NReq) : 1;
    localparam int IDX_W = (NArrays > 1) ? $clog2(NArrays) : 1;

    localparam logic [0:0] S_IDLE = IDLE;
    localparam logic [0:0] S_EXEC = EXEC;

    logic [0:0]         r_state;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_win_idx;
    logic               r_win_op;
    handle_t            r_win_handle;
    logic [MW-1:0]      r_freed_top;
    logic [MW-1:0]      r_allocs;
    logic [MW-1:0]      r_in_use;
    logic [NArrays-1:0] r_bitmap;
    handle_t            r_freed [NArrays];
    logic [NReq-1:0]    r_ack;
    logic [MW-1:0]      r_rsp_array;
    logic               r_rsp_error;
    logic               r_size_clr;
    logic [MW-1:0]      r_size_clr_idx;

    logic [NReq-1:0]    w_grant;
    logic [PTR_W-1:0]   w_win_idx;
    logic               w_any;
    handle_t            w_sel_handle;
    logic               w_stack_hit;
    logic               w_alloc_ok;
    handle_t            w_alloc_handle;
    logic               w_free_ok;
    logic               w_push;
    logic [PTR_W-1:0]   w_next_ptr;

    rr_arbiter #(
        .NReq  (NReq),
        .PTR_W (PTR_W)
    ) u_arb (
        .i_req   (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_win_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_sel_handle = '0;
        for (int r = 0; r < NReq; r++) begin
            if (w_grant[r])
                w_sel_handle = bus.req_array[r*MW +: MW];
        end
    end

    // Reuse freed handles first (LIFO), then grow the high-water mark.
    assign w_stack_hit    = (r_freed_top != '0);
    assign w_alloc_ok     = w_stack_hit || (r_allocs < MW'(NArrays));
    assign w_alloc_handle = w_stack_hit ? r_freed[IDX_W'(r_freed_top - MW'(1))] : r_allocs;
    // The range test guards the bitmap index against handles outside the heap.
    assign w_free_ok      = (r_win_handle < r_allocs) && r_bitmap[IDX_W'(r_win_handle)];
    assign w_push         = run && (r_state == S_EXEC) && (r_win_op == OP_FREE) && w_free_ok;
    assign w_next_ptr     = (r_win_idx == PTR_W'(NReq-1)) ? '0 : r_win_idx + PTR_W'(1);

    always_ff @(posedge clock) begin
        if (r_state == S_IDLE && w_any) begin
            r_win_idx    <= w_win_idx;
            r_win_op     <= bus.req_free[w_win_idx];
            r_win_handle <= w_sel_handle;
        end
        if (w_push)
            r_freed[IDX_W'(r_freed_top)] <= r_win_handle;
    end

    always_ff @(posedge clock) begin
        if (!run) begin
            r_state        <= S_IDLE;
            r_rr_ptr       <= '0;
            r_freed_top    <= '0;
            r_allocs       <= '0;
            r_in_use       <= '0;
            r_bitmap       <= '0;
            r_ack          <= '0;
            r_rsp_array    <= '0;
            r_rsp_error    <= 1'b0;
            r_size_clr     <= 1'b0;
            r_size_clr_idx <= '0;
        end else begin
            r_ack          <= '0;
            r_rsp_array    <= '0;
            r_rsp_error    <= 1'b0;
            r_size_clr     <= 1'b0;
            r_size_clr_idx <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any)
                        r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_state  <= S_IDLE;
                    r_ack    <= NReq'(1) << r_win_idx;
                    r_rr_ptr <= w_next_ptr;
                    if (r_win_op == OP_ALLOC) begin
                        if (w_alloc_ok) begin
                            if (w_stack_hit)
                                r_freed_top <= r_freed_top - MW'(1);
                            else
                                r_allocs <= r_allocs + MW'(1);
                            r_bitmap[IDX_W'(w_alloc_handle)] <= 1'b1;
                            r_in_use       <= r_in_use + MW'(1);
                            r_rsp_array    <= w_alloc_handle;
                            r_size_clr     <= 1'b1;
                            r_size_clr_idx <= w_alloc_handle;
                        end else begin
                            r_rsp_error <= 1'b1;
                        end
                    end else begin
                        if (w_free_ok) begin
                            r_freed_top <= r_freed_top + MW'(1);
                            r_bitmap[IDX_W'(r_win_handle)] <= 1'b0;
                            r_in_use    <= r_in_use - MW'(1);
                        end else begin
                            r_rsp_error <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ack          = r_ack;
    assign bus.rsp_array    = r_rsp_array;
    assign bus.rsp_error    = r_rsp_error;
    assign bus.size_clr     = r_size_clr;
    assign bus.size_clr_idx = r_size_clr_idx;
    assign bus.allocs       = r_allocs;
    assign bus.in_use       = r_in_use;
    assign bus.busy         = (r_state == S_EXEC);

endmodule

// File: tb/tb_array_allocator.sv
// Scoreboard bench for array_allocator (NArrays=4): directed operations push
// expected responses; a negedge monitor compares every ack against them.
module tb_array_allocator;
    import array_alloc_pkg::*;

    localparam int MW = 12;
    localparam int NA = 4;
    localparam int NR = 2;

    logic clock = 1'b0;
    logic run   = 1'b0;

    array_allocator_if #(.MemoryElementWidth(MW), .NReq(NR)) bus ();

    array_allocator #(
        .MemoryElementWidth (MW),
        .NArrays            (NA),
        .NReq               (NR)
    ) dut (
        .clock (clock),
        .run   (run),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [NR-1:0] ack;
        handle_t       arr;
        logic          err;
        logic          clr;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (bus.ack != '0) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack: got ack=%b expected none (t=%0t)", bus.ack, $time);
            end else begin
                e = sb.pop_front();
                check("ack_vec",   int'(bus.ack),       int'(e.ack));
                check("rsp_array", int'(bus.rsp_array), int'(e.arr));
                check("rsp_error", int'(bus.rsp_error), int'(e.err));
                check("size_clr",  int'(bus.size_clr),  int'(e.clr));
                if (e.clr)
                    check("size_clr_idx", int'(bus.size_clr_idx), int'(e.arr));
            end
        end else if (bus.size_clr || bus.rsp_error || bus.rsp_array != '0) begin
            checks++;
            failures++;
            $display("FAIL idle_outputs: got clr=%0b err=%0b arr=%0d expected all 0 (t=%0t)",
                     bus.size_clr, bus.rsp_error, bus.rsp_array, $time);
        end
    end

    task automatic push_exp(input int r, input int arr, input logic err, input logic clr);
        exp_t e;
        e.ack = NR'(1) << r;
        e.arr = handle_t'(arr);
        e.err = err;
        e.clr = clr;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge on which ack is seen.
    task automatic do_op(input int r, input logic fr, input int h,
                         input int exp_arr, input logic exp_err);
        int cyc;
        push_exp(r, exp_arr, exp_err, !fr && !exp_err);
        bus.req_valid[r]           = 1'b1;
        bus.req_free[r]            = fr;
        bus.req_array[r*MW +: MW]  = MW'(h);
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (!bus.ack[r] && cyc < 20);
        check("ack_latency", cyc, 2);
        bus.req_valid[r] = 1'b0;
    endtask

    task automatic do_reset();
        run           = 1'b0;
        bus.req_valid = '0;
        repeat (2) @(negedge clock);
        run = 1'b1;
    endtask

    initial begin
        int n0, n1, cyc;
        bus.req_valid = '0;
        bus.req_free  = '0;
        bus.req_array = '0;
        repeat (3) @(negedge clock);

        check("rst_ack",    int'(bus.ack),      0);
        check("rst_allocs", int'(bus.allocs),   0);
        check("rst_in_use", int'(bus.in_use),   0);
        check("rst_busy",   int'(bus.busy),     0);
        check("rst_clr",    int'(bus.size_clr), 0);
        run = 1'b1;

        // Fresh allocations.
        do_op(0, OP_ALLOC, 0, 0, 1'b0);
        do_op(0, OP_ALLOC, 0, 1, 1'b0);
        do_op(0, OP_ALLOC, 0, 2, 1'b0);
        check("allocs_after3", int'(bus.allocs), 3);
        check("in_use_after3", int'(bus.in_use), 3);

        // LIFO reuse.
        do_op(0, OP_FREE, 1, 0, 1'b0);
        do_op(0, OP_FREE, 0, 0, 1'b0);
        check("in_use_after_frees", int'(bus.in_use), 1);
        do_op(0, OP_ALLOC, 0, 0, 1'b0);
        do_op(0, OP_ALLOC, 0, 1, 1'b0);
        check("allocs_after_reuse", int'(bus.allocs), 3);
        check("in_use_after_reuse", int'(bus.in_use), 3);

        // Bad frees.
        do_op(1, OP_FREE, 7, 0, 1'b1);
        check("in_use_after_free7", int'(bus.in_use), 3);
        do_op(1, OP_FREE, 2, 0, 1'b0);
        do_op(1, OP_FREE, 2, 0, 1'b1);
        check("in_use_after_dbl", int'(bus.in_use), 2);
        check("allocs_after_dbl", int'(bus.allocs), 3);

        // Exhaustion.
        do_reset();
        do_op(1, OP_ALLOC, 0, 0, 1'b0);
        do_op(1, OP_ALLOC, 0, 1, 1'b0);
        do_op(1, OP_ALLOC, 0, 2, 1'b0);
        do_op(1, OP_ALLOC, 0, 3, 1'b0);
        do_op(1, OP_ALLOC, 0, 0, 1'b1);
        check("allocs_exhaust", int'(bus.allocs), 4);
        check("in_use_exhaust", int'(bus.in_use), 4);

        // Arbitration: both requesters hold req_valid for two ops each.
        do_reset();
        push_exp(0, 0, 1'b0, 1'b1);
        push_exp(1, 1, 1'b0, 1'b1);
        push_exp(0, 2, 1'b0, 1'b1);
        push_exp(1, 3, 1'b0, 1'b1);
        bus.req_free  = '0;
        bus.req_valid = 2'b11;
        n0  = 0;
        n1  = 0;
        cyc = 0;
        while ((n0 < 2 || n1 < 2) && cyc < 40) begin
            @(negedge clock);
            cyc++;
            if (bus.ack[0]) begin
                n0++;
                if (n0 == 2) bus.req_valid[0] = 1'b0;
            end
            if (bus.ack[1]) begin
                n1++;
                if (n1 == 2) bus.req_valid[1] = 1'b0;
            end
        end
        bus.req_valid = '0;
        check("arb_acks_r0", n0, 2);
        check("arb_acks_r1", n1, 2);
        check("arb_cycles",  cyc, 8);
        check("arb_allocs",  int'(bus.allocs), 4);

        // Reset during EXEC aborts the operation.
        bus.req_valid[0] = 1'b1;
        bus.req_free[0]  = OP_FREE;
        bus.req_array[0 +: MW] = MW'(0);
        @(negedge clock);
        check("midop_busy", int'(bus.busy), 1);
        run = 1'b0;
        @(negedge clock);
        check("midop_ack",    int'(bus.ack),    0);
        check("midop_allocs", int'(bus.allocs), 0);
        check("midop_in_use", int'(bus.in_use), 0);
        check("midop_busy0",  int'(bus.busy),   0);
        bus.req_valid = '0;
        @(negedge clock);
        run = 1'b1;
        do_op(0, OP_ALLOC, 0, 0, 1'b0);
        check("post_rst_allocs", int'(bus.allocs), 1);

        repeat (3) @(negedge clock);
        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
